// File: rtl/lsu_initiator.sv
// Load/store initiator between the execute stage and a length-strobed data memory port.
// It checks request alignment, holds the memory strobes for a fixed latency, and returns
// extended load data through a valid/ready handshake.
module lsu_initiator #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [1:0]      Mren,
  output logic [1:0]      Mwen,
  output logic [XLEN-1:0] raddr,
  output logic [XLEN-1:0] waddr,
  output logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  localparam logic [3:0] CntInit = (MEM_LATENCY == 0) ? 4'd0 : 4'(MEM_LATENCY - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            sgn_q, sgn_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            req_bad;
  logic            capture;

  function automatic logic [XLEN-1:0] mask_store(input logic [1:0]      size,
                                                 input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = '0;
    case (size)
      2'b01:   r = {{(XLEN-8){1'b0}}, d[7:0]};
      2'b10:   r = {{(XLEN-16){1'b0}}, d[15:0]};
      2'b11:   r = d;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] extend_load(input logic [1:0]      size,
                                                  input logic            sgn,
                                                  input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = '0;
    case (size)
      2'b01:   r = {{(XLEN-8){sgn & d[7]}}, d[7:0]};
      2'b10:   r = {{(XLEN-16){sgn & d[15]}}, d[15:0]};
      2'b11:   r = d;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign req_bad = (req_size == 2'b00) ||
                   (req_size == 2'b10 && req_addr[0]) ||
                   (req_size == 2'b11 && req_addr[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    capture = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = mask_store(req_size, req_wdata);
          rdata_d = '0;
          err_d   = req_bad;
          state_d = req_bad ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (MEM_LATENCY == 0) begin
          capture = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d   = CntInit;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Stores leave the response data at the zero loaded on accept.
    if (capture && !we_q) begin
      rdata_d = extend_load(size_q, sgn_q, rdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The write strobe exists only in ACCESS so each store hits memory exactly once.
  assign Mren       = ((state_q == StAccess || state_q == StWait) && !we_q) ? size_q : 2'b00;
  assign Mwen       = (state_q == StAccess && we_q) ? size_q : 2'b00;
  assign raddr      = addr_q;
  assign waddr      = addr_q;
  assign wdata      = wdata_q;
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_initiator.sv
// Bench for lsu_initiator: two instances (latency 1 and 3) share stimulus and are checked
// cycle by cycle against an arithmetic reference model of the access rules.
module tb_lsu_initiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_we, req_signed, resp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rdata;
  int          sel;
  int          checks = 0;
  int          errors = 0;

  logic        rv_w[2], rr_w[2];
  logic        req_ready_w[2], resp_valid_w[2], resp_err_w[2];
  logic [31:0] resp_rdata_w[2], raddr_w[2], waddr_w[2], wdata_w[2];
  logic [1:0]  mren_w[2], mwen_w[2];

  assign rv_w[0] = req_valid && (sel == 0);
  assign rv_w[1] = req_valid && (sel == 1);
  assign rr_w[0] = resp_ready && (sel == 0);
  assign rr_w[1] = resp_ready && (sel == 1);

  lsu_initiator #(.MEM_LATENCY(1), .XLEN(32)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(rv_w[0]), .req_ready(req_ready_w[0]),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid_w[0]), .resp_ready(rr_w[0]),
    .resp_rdata(resp_rdata_w[0]), .resp_err(resp_err_w[0]), .Mren(mren_w[0]),
    .Mwen(mwen_w[0]), .raddr(raddr_w[0]), .waddr(waddr_w[0]), .wdata(wdata_w[0]),
    .rdata(rdata)
  );

  lsu_initiator #(.MEM_LATENCY(3), .XLEN(32)) u_dut_l3 (
    .clk(clk), .rst(rst), .req_valid(rv_w[1]), .req_ready(req_ready_w[1]),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid_w[1]), .resp_ready(rr_w[1]),
    .resp_rdata(resp_rdata_w[1]), .resp_err(resp_err_w[1]), .Mren(mren_w[1]),
    .Mwen(mwen_w[1]), .raddr(raddr_w[1]), .waddr(waddr_w[1]), .wdata(wdata_w[1]),
    .rdata(rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (t=%0t inst=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  function automatic int lat_of(input int s);
    return (s == 1) ? 3 : 1;
  endfunction

  function automatic longint nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 64'd1 : (64'd1 << (size - 2'd1));
  endfunction

  function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b00) return 1'b1;
    return (longint'(addr) % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] model_trunc(input logic [1:0] size, input logic [31:0] v);
    longint m;
    m = 64'd1 << (8 * nbytes(size));
    return 32'(longint'(v) % m);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] v);
    longint m, r;
    m = 64'd1 << (8 * nbytes(size));
    r = longint'(model_trunc(size, v));
    if (sgn && nbytes(size) < 4 && r >= m / 2) r = r - m;
    return 32'(r);
  endfunction

  task automatic junk_fields();
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic check_idle_strobes(input string tag);
    check_eq({tag, "_mren"}, 32'(mren_w[sel]), 32'd0);
    check_eq({tag, "_mwen"}, 32'(mwen_w[sel]), 32'd0);
  endtask

  // One complete transaction on instance s, checked every cycle from accept to handshake.
  task automatic run_txn(input int s, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int hold, input bit junk);
    bit          err;
    int          lat, total;
    logic [31:0] exp_rd;
    err    = model_err(size, addr);
    lat    = lat_of(s);
    total  = err ? 1 : 2 + lat;
    exp_rd = (we || err) ? 32'd0 : model_load(size, sgn, rd);
    sel    = s;

    @(negedge clk);
    check_eq("accept_ready", 32'(req_ready_w[sel]), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wd;
    resp_ready = 1'b0;
    rdata      = $urandom;
    @(negedge clk);
    req_valid = junk;
    junk_fields();

    for (int k = 1; k < total; k++) begin
      rdata = (k == 1 + lat) ? rd : $urandom;
      check_eq("busy_ready", 32'(req_ready_w[sel]), 32'd0);
      check_eq("busy_valid", 32'(resp_valid_w[sel]), 32'd0);
      if (we) begin
        check_eq("st_mwen", 32'(mwen_w[sel]), (k == 1) ? 32'(size) : 32'd0);
        check_eq("st_mren", 32'(mren_w[sel]), 32'd0);
        check_eq("st_waddr", waddr_w[sel], addr);
        if (k == 1) check_eq("st_wdata", wdata_w[sel], model_trunc(size, wd));
      end else begin
        check_eq("ld_mren", 32'(mren_w[sel]), 32'(size));
        check_eq("ld_mwen", 32'(mwen_w[sel]), 32'd0);
        check_eq("ld_raddr", raddr_w[sel], addr);
      end
      @(negedge clk);
      junk_fields();
    end

    rdata = $urandom;
    check_eq("resp_valid", 32'(resp_valid_w[sel]), 32'd1);
    check_eq("resp_err", 32'(resp_err_w[sel]), 32'(err));
    check_eq("resp_rdata", resp_rdata_w[sel], exp_rd);
    check_idle_strobes("resp");

    for (int h = 0; h < hold; h++) begin
      req_valid = junk;
      junk_fields();
      rdata = $urandom;
      @(negedge clk);
      check_eq("hold_valid", 32'(resp_valid_w[sel]), 32'd1);
      check_eq("hold_rdata", resp_rdata_w[sel], exp_rd);
      check_eq("hold_err", 32'(resp_err_w[sel]), 32'(err));
      check_eq("hold_ready", 32'(req_ready_w[sel]), 32'd0);
      check_idle_strobes("hold");
    end

    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("post_valid", 32'(resp_valid_w[sel]), 32'd0);
    check_eq("post_ready", 32'(req_ready_w[sel]), 32'd1);
    check_idle_strobes("post");
  endtask

  task automatic check_reset_state(input int s);
    sel = s;
    check_eq("rst_req_ready", 32'(req_ready_w[sel]), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid_w[sel]), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err_w[sel]), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata_w[sel], 32'd0);
    check_eq("rst_raddr", raddr_w[sel], 32'd0);
    check_eq("rst_waddr", waddr_w[sel], 32'd0);
    check_eq("rst_wdata", wdata_w[sel], 32'd0);
    check_idle_strobes("rst");
  endtask

  // Word load on the latency-3 instance, reset while it sits in WAIT.
  task automatic reset_mid_wait();
    sel = 1;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_size   = 2'b11;
    req_signed = 1'b0;
    req_addr   = 32'h8000_0020;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_wait_mren", 32'(mren_w[sel]), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_mren", 32'(mren_w[sel]), 32'd0);
    check_eq("mid_rst_ready", 32'(req_ready_w[sel]), 32'd1);
    check_eq("mid_rst_valid", 32'(resp_valid_w[sel]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("mid_rst_no_resp", 32'(resp_valid_w[sel]), 32'd0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    sel        = 0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    rdata      = '0;
    junk_fields();
    repeat (3) @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    rst = 1'b0;

    run_txn(0, 1'b0, 2'b01, 1'b1, 32'h8000_0003, 32'h0, 32'h0000_0080, 0, 1'b0);
    run_txn(0, 1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'h0, 32'h1234_ABCD, 0, 1'b0);
    run_txn(0, 1'b0, 2'b10, 1'b1, 32'h8000_0002, 32'h0, 32'h1234_ABCD, 0, 1'b0);
    run_txn(0, 1'b1, 2'b01, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    run_txn(0, 1'b0, 2'b11, 1'b0, 32'h8000_0002, 32'h0, 32'h5555_AAAA, 0, 1'b0);
    run_txn(0, 1'b0, 2'b00, 1'b0, 32'h8000_0000, 32'h0, 32'h5555_AAAA, 0, 1'b0);
    run_txn(0, 1'b0, 2'b11, 1'b0, 32'h8000_0004, 32'h0, 32'hCAFE_F00D, 5, 1'b1);
    run_txn(0, 1'b1, 2'b10, 1'b0, 32'h8000_0006, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    run_txn(1, 1'b0, 2'b01, 1'b1, 32'h8000_0001, 32'h0, 32'h0000_007F, 0, 1'b1);
    run_txn(1, 1'b1, 2'b11, 1'b0, 32'h8000_0008, 32'h89AB_CDEF, 32'h0, 2, 1'b1);

    reset_mid_wait();
    run_txn(1, 1'b0, 2'b11, 1'b0, 32'h8000_0020, 32'h0, 32'h1357_9BDF, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn($urandom_range(0, 1), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom,
              $urandom, $urandom_range(0, 3), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_initiator.md
Name: lsu_initiator

Overview:
- Load/store initiator between the core's execute stage and the data memory port.
- The memory port is the 2-bit-length DPI read/write interface: Mren, Mwen, raddr, waddr, wdata, rdata.
- Accepts one load or store per handshake and checks alignment.
- Drives the memory strobes for a bounded number of cycles, then sign/zero-extends load data and returns a response through a valid/ready handshake.

Parameters:
- MEM_LATENCY, 1, cycles from first strobe cycle to rdata sample (range 0..15).
- XLEN, 32, address/data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  01 byte, 10 half, 11 word; 00 illegal.
- req_signed  input  1  loads: sign-extend when 1.
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data, right-justified.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  XLEN  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal-size request.
- Mren  output  2  read length strobe, same encoding as req_size; 00 idle.
- Mwen  output  2  write length strobe; 00 idle.
- raddr  output  XLEN  read address.
- waddr  output  XLEN  write address.
- wdata  output  XLEN  write data, upper unused bits zeroed.
- rdata  input  XLEN  memory read data, right-justified.

Behaviour:
- Reset: state IDLE, req_ready 1, resp_valid 0, resp_err 0, resp_rdata 0, Mren/Mwen 00, raddr/waddr/wdata 0, counter 0.
- Reset mid-operation: abandons the transaction. Strobes drop to 00 the cycle after rst is sampled. No response is produced.
- IDLE: a request is accepted on req_valid && req_ready. Address, size, we, signed and masked wdata are latched.
  - Error case: size 00, half with addr[0]=1, or word with addr[1:0]!=0. Go to RESP with resp_err=1 and resp_rdata=0. No strobe is ever issued.
  - Otherwise go to ACCESS.
- ACCESS (1 cycle):
  - Store: Mwen=size for exactly this one cycle, so the write is performed once.
  - Load: Mren=size.
  - MEM_LATENCY=0: load captures rdata this cycle, then RESP.
  - MEM_LATENCY>0: counter loads MEM_LATENCY-1, go to WAIT.
- WAIT:
  - Loads keep Mren asserted and raddr stable. Stores keep Mwen at 00 and waddr stable.
  - Counter decrements each cycle. At 0, a load captures rdata and the state goes to RESP.
- Load data extension:
  - byte: rdata[7:0]; signed fills with bit 7, else zero-fill.
  - half: rdata[15:0]; signed fills with bit 15, else zero-fill.
  - word: rdata unchanged.
- Store wdata masking: byte keeps [7:0], half keeps [15:0], word keeps all bits; the rest is 0.
- RESP:
  - resp_valid=1. Strobes are 00.
  - resp_rdata and resp_err hold stable until resp_valid && resp_ready, then go to IDLE.
  - No new request is accepted in the same cycle; req_ready rises the cycle after the handshake.
- Total latency, valid request to resp_valid: 2+MEM_LATENCY cycles.
- Total latency, error request to resp_valid: 1 cycle.
- Mren and Mwen are never both non-zero. Both are 00 outside ACCESS/WAIT.
- req_valid while busy is ignored: no queuing and no corruption of latched fields.

Test Plan:
1. Reset, then signed byte load at 0x8000_0003 with rdata=0x0000_0080, MEM_LATENCY=1 -> Mren=01 for 2 cycles, raddr=0x8000_0003; resp_rdata=0xFFFF_FF80, resp_err=0, resp_valid 3 cycles after accept.
2. Unsigned half load at 0x8000_0002 with rdata=0x1234_ABCD -> resp_rdata=0x0000_ABCD. Same load with req_signed=1 -> 0xFFFF_ABCD.
3. Byte store at 0x8000_0010 with req_wdata=0xDEAD_BEEF -> Mwen=01 for exactly one cycle, wdata=0x0000_00EF, waddr=0x8000_0010, Mren=00 throughout; resp_rdata=0.
4. Word load at 0x8000_0002 -> resp_err=1 one cycle after accept, Mren/Mwen stay 00. Size 00 request -> same error response.
5. Hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid/resp_rdata stable, req_ready=0, a second req_valid is ignored. Release resp_ready -> IDLE next cycle and the new request is accepted.
6. Assert rst during WAIT of a word load with MEM_LATENCY=3 -> next cycle Mren=00, req_ready=1, resp_valid=0. A following word load returns the correct data.
